// File: rtl/trace_pkg.sv
// Shared types for the pipeline trace monitor: FSM states, flag bit positions
// and the packed trace-entry width derived from the datapath widths.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALTED    = 2'd1,
    ST_TIMED_OUT = 2'd2
  } state_t;

  localparam int FLAG_WB   = 0;
  localparam int FLAG_MEM  = 1;
  localparam int FLAG_HALT = 2;
  localparam int FLAG_TO   = 3;
  localparam int FLAG_W    = 4;

  // Entry layout, MSB first: {stamp, flags, pc, rd, wdata, maddr, mdata}
  function automatic int entry_w(input int cnt_w, input int pc_w, input int ra_w,
                                 input int data_w, input int ma_w);
    return cnt_w + FLAG_W + pc_w + ra_w + data_w + ma_w + data_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through circular buffer; head is read straight from the
// storage registers, so a write is visible on the head one cycle later.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_dat_i,
  output logic                     drop_o,
  output logic                     rd_vld_o,
  input  logic                     rd_rdy_i,
  output logic [W-1:0]             rd_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, pop, push;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign rd_vld_o = (cnt_q != '0);
  assign pop      = rd_vld_o & rd_rdy_i;
  // A pop frees the slot in the same cycle, so a full buffer still accepts
  assign push     = wr_en_i & (~full | pop);
  assign drop_o   = wr_en_i & full & ~pop;
  assign count_o  = cnt_q;
  assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/pipeline_trace_monitor.sv
// Time-stamped trace capture of writeback/memory/halt events with a watchdog;
// RUN ends in HALTED or TIMED_OUT until reset, while the buffer keeps draining.
module pipeline_trace_monitor
  import trace_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 16,
  parameter int RA_W    = 3,
  parameter int MA_W    = 8,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cap_all,
  input  logic [PC_W-1:0]          pc_in,
  input  logic                     stall_in,
  input  logic                     halt_in,
  input  logic                     wb_en,
  input  logic [RA_W-1:0]          wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mem_we,
  input  logic [MA_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [CNT_W-1:0]         rd_stamp,
  output logic [3:0]               rd_flags,
  output logic [PC_W-1:0]          rd_pc,
  output logic [RA_W-1:0]          rd_rd,
  output logic [DATA_W-1:0]        rd_wdata,
  output logic [MA_W-1:0]          rd_maddr,
  output logic [DATA_W-1:0]        rd_mdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic                     done,
  output logic                     timed_out
);
  localparam int EW = entry_w(CNT_W, PC_W, RA_W, DATA_W, MA_W);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  stamp_q, wdog_q;
  logic              overflow_q;
  logic [7:0]        drop_cnt_q;
  logic              in_run, expiry, capture, drop;
  logic [3:0]        flags;
  logic [EW-1:0]     wr_dat, head_dat;

  assign in_run  = (state_q == ST_RUN);
  assign expiry  = (TIMEOUT != 0) && in_run && !halt_in &&
                   (wdog_q == CNT_W'(TIMEOUT - 1));
  assign capture = in_run & (wb_en | mem_we | halt_in | expiry | (cap_all & ~stall_in));

  always_comb begin
    flags            = '0;
    flags[FLAG_WB]   = wb_en;
    flags[FLAG_MEM]  = mem_we;
    flags[FLAG_HALT] = halt_in;
    flags[FLAG_TO]   = expiry;
  end

  // Fields of events that did not occur are zeroed so entries compare cleanly
  assign wr_dat = {stamp_q, flags, pc_in,
                   wb_en  ? wb_rd     : '0,
                   wb_en  ? wb_data   : '0,
                   mem_we ? mem_addr  : '0,
                   mem_we ? mem_wdata : '0};

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (halt_in)     state_d = ST_HALTED;
      else if (expiry) state_d = ST_TIMED_OUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_q    <= '0;
      wdog_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      stamp_q <= stamp_q + CNT_W'(1);
      if (in_run) wdog_q <= wdog_q + CNT_W'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (capture),
    .wr_dat_i (wr_dat),
    .drop_o   (drop),
    .rd_vld_o (rd_valid),
    .rd_rdy_i (rd_ready),
    .rd_dat_o (head_dat),
    .count_o  (count)
  );

  assign {rd_stamp, rd_flags, rd_pc, rd_rd, rd_wdata, rd_maddr, rd_mdata} = head_dat;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign done      = ~in_run;
  assign timed_out = (state_q == ST_TIMED_OUT);

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Directed plan scenarios plus randomized traffic, every cycle compared
// against a queue-based model of the trace buffer and run status.
module tb_pipeline_trace_monitor;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 30;

  logic        clk, reset, cap_all, stall_in, halt_in, wb_en, mem_we, rd_ready;
  logic [15:0] pc_in, wb_data, mem_wdata;
  logic [2:0]  wb_rd;
  logic [7:0]  mem_addr;
  logic        rd_valid, overflow, done, timed_out;
  logic [15:0] rd_stamp, rd_pc, rd_wdata, rd_mdata;
  logic [3:0]  rd_flags;
  logic [2:0]  rd_rd;
  logic [7:0]  rd_maddr, drop_cnt;
  logic [4:0]  count;

  pipeline_trace_monitor dut (
    .clk(clk), .reset(reset), .cap_all(cap_all), .pc_in(pc_in),
    .stall_in(stall_in), .halt_in(halt_in), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_stamp(rd_stamp), .rd_flags(rd_flags), .rd_pc(rd_pc), .rd_rd(rd_rd),
    .rd_wdata(rd_wdata), .rd_maddr(rd_maddr), .rd_mdata(rd_mdata),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .done(done),
    .timed_out(timed_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] stamp;
    logic [3:0]  fl;
    logic [15:0] pc;
    logic [2:0]  rd;
    logic [15:0] wd;
    logic [7:0]  ma;
    logic [15:0] md;
  } ent_t;

  ent_t q[$];
  int   m_stamp, m_run_cycles, m_drops;
  bit   m_halted, m_timed, m_ovf;
  int   tests, fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge, computed from the inputs presented in that cycle
  task automatic model_edge();
    bit   running, expire, cap;
    ent_t e;
    if (reset) begin
      q.delete();
      m_stamp = 0; m_run_cycles = 0; m_drops = 0;
      m_halted = 0; m_timed = 0; m_ovf = 0;
      return;
    end
    running = !m_halted && !m_timed;
    expire  = running && (TIMEOUT != 0) && (m_run_cycles == TIMEOUT - 1) && !halt_in;
    cap     = running && (wb_en || mem_we || halt_in || expire || (cap_all && !stall_in));
    if (q.size() > 0 && rd_ready) void'(q.pop_front());
    if (cap) begin
      e.stamp = 16'(m_stamp);
      e.fl    = {expire, halt_in, mem_we, wb_en};
      e.pc    = pc_in;
      e.rd    = wb_en  ? wb_rd     : 3'd0;
      e.wd    = wb_en  ? wb_data   : 16'd0;
      e.ma    = mem_we ? mem_addr  : 8'd0;
      e.md    = mem_we ? mem_wdata : 16'd0;
      if (q.size() < DEPTH) q.push_back(e);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    if (running) begin
      if (halt_in)     m_halted = 1;
      else if (expire) m_timed  = 1;
      m_run_cycles++;
    end
    m_stamp = (m_stamp + 1) % 65536;
  endtask

  task automatic check_all();
    ent_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    chk("rd_valid",  rd_valid,  q.size() > 0);
    chk("count",     count,     q.size());
    chk("rd_stamp",  rd_stamp,  e.stamp);
    chk("rd_flags",  rd_flags,  e.fl);
    chk("rd_pc",     rd_pc,     e.pc);
    chk("rd_rd",     rd_rd,     e.rd);
    chk("rd_wdata",  rd_wdata,  e.wd);
    chk("rd_maddr",  rd_maddr,  e.ma);
    chk("rd_mdata",  rd_mdata,  e.md);
    chk("overflow",  overflow,  m_ovf);
    chk("drop_cnt",  drop_cnt,  m_drops);
    chk("done",      done,      m_halted || m_timed);
    chk("timed_out", timed_out, m_timed);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    reset = 0; cap_all = 0; stall_in = 0; halt_in = 0; wb_en = 0; mem_we = 0;
    rd_ready = 0; wb_rd = '0; wb_data = '0; mem_addr = '0; mem_wdata = '0;
    pc_in = 16'($urandom);
  endtask

  task automatic do_reset();
    idle(); reset = 1;
    step(); step();
    idle();
  endtask

  initial begin
    tests = 0; fails = 0;
    q.delete();
    m_stamp = 0; m_run_cycles = 0; m_drops = 0;
    m_halted = 0; m_timed = 0; m_ovf = 0;

    // Reset state, then single writeback at stamp 4
    do_reset();
    chk("reset_valid", rd_valid, 1'b0);
    chk("reset_count", count, 5'd0);
    chk("reset_done",  done, 1'b0);
    while (m_stamp != 4) begin idle(); step(); end
    idle(); wb_en = 1; wb_rd = 3'd3; wb_data = 16'h0005; step();
    chk("t1_count", count, 5'd1);
    chk("t1_stamp", rd_stamp, 16'd4);
    chk("t1_flags", rd_flags, 4'b0001);
    chk("t1_rd",    rd_rd, 3'd3);
    chk("t1_wdata", rd_wdata, 16'h0005);

    // Pop while a combined writeback + memory-write entry is pushed
    idle(); rd_ready = 1;
    wb_en = 1; wb_rd = 3'd1; wb_data = 16'h000A;
    mem_we = 1; mem_addr = 8'd100; mem_wdata = 16'h0007; step();
    chk("t2_count", count, 5'd1);
    chk("t2_flags", rd_flags, 4'b0011);
    chk("t2_maddr", rd_maddr, 8'd100);
    chk("t2_mdata", rd_mdata, 16'h0007);
    chk("t2_wdata", rd_wdata, 16'h000A);

    // Overflow: 20 events into a 16-deep buffer without draining
    do_reset();
    for (int i = 0; i < 20; i++) begin idle(); wb_en = 1; wb_data = 16'(i); step(); end
    chk("t3_count", count, 5'd16);
    chk("t3_ovf",   overflow, 1'b1);
    chk("t3_drops", drop_cnt, 8'd4);
    for (int i = 0; i < 16; i++) begin
      chk("t3_order", rd_stamp, 16'(i));
      idle(); rd_ready = 1; step();
    end

    // Halt at stamp 12, later writebacks ignored
    do_reset();
    while (m_stamp != 12) begin idle(); step(); end
    idle(); halt_in = 1; step();
    chk("t4_flags", rd_flags, 4'b0100);
    chk("t4_stamp", rd_stamp, 16'd12);
    chk("t4_done",  done, 1'b1);
    for (int i = 0; i < 30; i++) begin idle(); wb_en = 1; step(); end
    chk("t4_count", count, 5'd1);
    chk("t4_to",    timed_out, 1'b0);

    // Watchdog expiry at stamp 29
    do_reset();
    while (m_stamp != 29) begin idle(); step(); end
    idle(); step();
    chk("t5_flags", rd_flags, 4'b1000);
    chk("t5_stamp", rd_stamp, 16'd29);
    chk("t5_done",  done, 1'b1);
    chk("t5_to",    timed_out, 1'b1);

    // Halt coinciding with expiry resolves to HALTED
    do_reset();
    while (m_stamp != 29) begin idle(); step(); end
    idle(); halt_in = 1; step();
    chk("t5b_flags", rd_flags, 4'b0100);
    chk("t5b_done",  done, 1'b1);
    chk("t5b_to",    timed_out, 1'b0);

    // cap_all with alternating stall, then reset mid-drain
    do_reset();
    for (int i = 0; i < 8; i++) begin idle(); cap_all = 1; stall_in = (i % 2 == 0); step(); end
    chk("t6_count", count, 5'd4);
    chk("t6_flags", rd_flags, 4'b0000);
    idle(); rd_ready = 1; step(); step();
    idle(); reset = 1; step();
    chk("t6_rst_count", count, 5'd0);
    chk("t6_rst_valid", rd_valid, 1'b0);
    chk("t6_rst_ovf",   overflow, 1'b0);

    // Randomized traffic, including occasional mid-run resets
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        idle();
        reset     = ($urandom % 80) == 0;
        cap_all   = ($urandom % 2) == 0;
        stall_in  = ($urandom % 3) == 0;
        halt_in   = ($urandom % 40) == 0;
        wb_en     = ($urandom % 3) == 0;
        wb_rd     = 3'($urandom);
        wb_data   = 16'($urandom);
        mem_we    = ($urandom % 4) == 0;
        mem_addr  = 8'($urandom);
        mem_wdata = 16'($urandom);
        rd_ready  = ($urandom % 3) == 0;
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
